vga_timing_gen: RTL and testbench

Raster timing generator for the whack-a-mole display path. Produces the pixel strobe, the current pixel coordinates `x`/`y`, `video_on`, and the `hsync`/`vsync` pulses for 640x480@60 Hz. `oval_display` and `mole_animation` consume the coordinate and blanking outputs; `hsync`/`vsync` go to the VGA connector. It is the source end of the `x`/`y`/`video_on` interface.

---
 rtl/vga_timing_gen.sv | 112 +++++++++++
 tb/tb_vga_timing_gen.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- raster timing generator for the whack-a-mole display path.
//
// Generates the pixel strobe, pixel coordinates, blanking decode and sync
// pulses for a 640x480@60 Hz raster. The default geometry can be overridden
// through the parameters.
//
// Configuration macro: VGA_TICK_DIV_EN
//   defined   : clk is the 100 MHz system clock and a divide-by-4 counter
//               produces p_tick every 4th clk.
//   undefined : clk is the pixel clock and p_tick is tied to 1.
//
// Ports:
//   clk          in   system clock (pixel clock when the divider is absent)
//   rst          in   synchronous, active-high reset
//   p_tick       out  pixel strobe; counters advance at the end of a p_tick cycle
//   x            out  current pixel column, 0..H_TOTAL-1 (registered)
//   y            out  current line, 0..V_TOTAL-1 (registered)
//   video_on     out  combinational: x inside the visible width and y inside the visible height
//   hsync        out  horizontal sync, registered, active level SYNC_POL
//   vsync        out  vertical sync, registered, active level SYNC_POL
//   frame_start  out  one-clk pulse on the last pixel tick of a frame
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] H_LAST   = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST   = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;

`ifdef VGA_TICK_DIV_EN
    logic [1:0] div_q;

    // Free-running divider; reset realigns it so the first pixel after
    // reset lasts a full 4 clocks.
    always_ff @(posedge clk) begin
        if (rst) div_q <= 2'd0;
        else     div_q <= div_q + 2'd1;
    end

    assign p_tick = (div_q == 2'd3);
`else
    assign p_tick = 1'b1;
`endif

    always_comb begin
        h_d  = h_q;
        v_d  = v_q;
        hs_d = hs_q;
        vs_d = vs_q;
        if (p_tick) begin
            if (h_q == H_LAST) begin
                h_d = 10'd0;
                v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
            // Syncs decode the *next* position so they switch on the same
            // edge as x/y, with no skew.
            hs_d = (h_d >= HS_FIRST && h_d <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
            vs_d = (v_d >= VS_FIRST && v_d <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q  <= 10'd0;
            v_q  <= 10'd0;
            hs_q <= ~SYNC_POL;
            vs_q <= ~SYNC_POL;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
        end
    end

    assign x           = h_q;
    assign y           = v_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign video_on    = (h_q < H_VIS) && (v_q < V_VIS);
    assign frame_start = p_tick && (h_q == H_LAST) && (v_q == V_LAST);

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
module tb_vga_timing_gen;
`ifdef VGA_TICK_DIV_EN
    localparam int DIV = 4;
`else
    localparam int DIV = 1;
`endif
    // DUT A: full 640x480 geometry (line-level checks only; a frame is too long)
    localparam int A_HD = 640, A_HF = 16, A_HS = 96, A_HB = 48;
    localparam int A_VD = 480, A_VF = 10, A_VS = 2,  A_VB = 33;
    // DUT B: shrunken geometry so several whole frames fit in the run
    localparam int B_HD = 8, B_HF = 2, B_HS = 3, B_HB = 2;
    localparam int B_VD = 6, B_VF = 1, B_VS = 2, B_VB = 2;
    localparam int B_HT = B_HD + B_HF + B_HS + B_HB;   // 15
    localparam int B_VT = B_VD + B_VF + B_VS + B_VB;   // 11

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       a_pt, a_vo, a_hs, a_vs, a_fs;
    logic [9:0] a_x, a_y;
    logic       b_pt, b_vo, b_hs, b_vs, b_fs;
    logic [9:0] b_x, b_y;

    vga_timing_gen u_a (
        .clk(clk), .rst(rst), .p_tick(a_pt), .x(a_x), .y(a_y), .video_on(a_vo),
        .hsync(a_hs), .vsync(a_vs), .frame_start(a_fs)
    );

    vga_timing_gen #(
        .H_DISPLAY(B_HD), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
        .V_DISPLAY(B_VD), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB),
        .SYNC_POL(1'b0)
    ) u_b (
        .clk(clk), .rst(rst), .p_tick(b_pt), .x(b_x), .y(b_y), .video_on(b_vo),
        .hsync(b_hs), .vsync(b_vs), .frame_start(b_fs)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: everything follows from the number of clock edges since reset.
    typedef struct {
        int x; int y; bit pt; bit hs; bit vs; bit vo; bit fs;
    } exp_t;

    function automatic exp_t model(int unsigned n, int hd, int hf, int hs, int hb,
                                   int vd, int vf, int vs, int vb);
        exp_t m;
        int ht = hd + hf + hs + hb;
        int vt = vd + vf + vs + vb;
        int unsigned pix = n / DIV;
        m.x  = pix % ht;
        m.y  = (pix / ht) % vt;
        m.pt = (n % DIV) == DIV - 1;
        m.hs = !(m.x >= hd + hf && m.x < hd + hf + hs);
        m.vs = !(m.y >= vd + vf && m.y < vd + vf + vs);
        m.vo = (m.x < hd) && (m.y < vd);
        m.fs = m.pt && (m.x == ht - 1) && (m.y == vt - 1);
        return m;
    endfunction

    int unsigned n = 0;
    always @(posedge clk) n <= rst ? 0 : n + 1;

    bit chk_on = 0;
    always @(negedge clk) begin
        exp_t ea, eb;
        if (chk_on) begin
            ea = model(n, A_HD, A_HF, A_HS, A_HB, A_VD, A_VF, A_VS, A_VB);
            eb = model(n, B_HD, B_HF, B_HS, B_HB, B_VD, B_VF, B_VS, B_VB);
            chk("a_x", a_x, ea.x);   chk("a_y", a_y, ea.y);
            chk("a_ptick", a_pt, ea.pt); chk("a_hsync", a_hs, ea.hs);
            chk("a_vsync", a_vs, ea.vs); chk("a_video_on", a_vo, ea.vo);
            chk("a_frame_start", a_fs, ea.fs);
            chk("b_x", b_x, eb.x);   chk("b_y", b_y, eb.y);
            chk("b_ptick", b_pt, eb.pt); chk("b_hsync", b_hs, eb.hs);
            chk("b_vsync", b_vs, eb.vs); chk("b_video_on", b_vo, eb.vo);
            chk("b_frame_start", b_fs, eb.fs);
        end
    end

    // Edge/period monitors, measured directly on the outputs.
    bit          mon_on = 0;
    logic        a_hs_p = 1'b1, b_vs_p = 1'b1;
    int unsigned a_fall_n = 0, b_vfall_n = 0, b_fs_n = 0;
    int          a_falls = 0, b_frames = 0, b_vid = 0;
    always @(negedge clk) begin
        a_hs_p <= a_hs;
        b_vs_p <= b_vs;
        if (mon_on) begin
            if (a_hs_p && !a_hs) begin
                chk("a_hsync_fall_x", a_x, A_HD + A_HF);
                if (a_falls > 0) chk("a_line_period", n - a_fall_n, (A_HD + A_HF + A_HS + A_HB) * DIV);
                a_fall_n <= n;
                a_falls  <= a_falls + 1;
            end
            if (!a_hs_p && a_hs && a_falls > 0)
                chk("a_hsync_low_len", n - a_fall_n, A_HS * DIV);
            if (b_vs_p && !b_vs) begin
                chk("b_vsync_fall_y", b_y, B_VD + B_VF);
                b_vfall_n <= n;
            end
            if (!b_vs_p && b_vs)
                chk("b_vsync_low_len", n - b_vfall_n, B_VS * B_HT * DIV);
            if (b_fs) begin
                chk("b_visible_ticks", b_vid, B_HD * B_VD);
                if (b_frames > 0) chk("b_frame_period", n - b_fs_n, B_HT * B_VT * DIV);
                b_fs_n   <= n;
                b_frames <= b_frames + 1;
                b_vid    <= 0;
            end else if (b_pt && b_vo) begin
                b_vid <= b_vid + 1;
            end
        end
    end

    initial begin
        int k;
        int rx, ry, ph;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_on = 1;
        chk("rst_x", a_x, 0);
        chk("rst_y", a_y, 0);
        chk("rst_hsync", a_hs, 1);
        chk("rst_vsync", a_vs, 1);
        chk("rst_frame_start", a_fs, 0);
        chk("rst_video_on", a_vo, 1);
        chk("rst_ptick", a_pt, DIV == 1);
        rst = 1'b0;
        mon_on = 1;

        // First strobe lands in the DIV-th cycle counting the release cycle.
        k = 0;
        while (!a_pt && k < 16) begin @(negedge clk); k++; end
        chk("first_ptick_delay", k, DIV - 1);

        // Two full hsync periods on A and several frames on B.
        k = 0;
        while ((a_falls < 2 || b_frames < 3) && k < 20000) begin @(negedge clk); k++; end
        chk("line_and_frame_seen", (a_falls >= 2) && (b_frames >= 3), 1);

        // Frame wrap on B.
        k = 0;
        while (!(b_pt && b_x == B_HT - 1 && b_y == B_VT - 1) && k < 4 * B_HT * B_VT * DIV) begin
            @(negedge clk); k++;
        end
        chk("wrap_reached", b_pt && b_x == B_HT - 1 && b_y == B_VT - 1, 1);
        chk("wrap_frame_start", b_fs, 1);
        @(negedge clk);
        chk("wrap_x", b_x, 0);
        chk("wrap_y", b_y, 0);
        chk("wrap_frame_start_drop", b_fs, 0);

        // Mid-frame resets at random positions and divider phase.
        mon_on = 0;
        ph = (DIV > 1) ? 2 : 0;
        for (int r = 0; r < 4; r++) begin
            rx = $urandom_range(B_HT - 1, 1);
            ry = $urandom_range(B_VT - 1, 0);
            k = 0;
            while (!(b_x == rx && b_y == ry && (n % DIV) == ph) && k < 4 * B_HT * B_VT * DIV) begin
                @(negedge clk); k++;
            end
            chk("midrst_reached", b_x == rx && b_y == ry, 1);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("midrst_x", b_x, 0);
            chk("midrst_y", b_y, 0);
            chk("midrst_ptick", b_pt, DIV == 1);
            chk("midrst_a_x", a_x, 0);
            repeat (DIV - 1) @(negedge clk);
            chk("midrst_still_x0", b_x, 0);
            @(negedge clk);
            chk("midrst_x1", b_x, 1);
            repeat ($urandom_range(200, 20)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
